// File: rtl/calc_sequencer_if.sv
// ALU handshake bundle: operands, operation and start pulse out; result, sign, error and done back.
interface calc_sequencer_if #(
    parameter int W = 40
);
    logic         o_alu_start;
    logic [W-1:0] o_s1;
    logic [W-1:0] o_s2;
    logic [1:0]   o_op;
    logic [W-1:0] i_res;
    logic         i_res_sign;
    logic         i_res_err;
    logic         i_alu_done;

    modport master (
        output o_alu_start, o_s1, o_s2, o_op,
        input  i_res, i_res_sign, i_res_err, i_alu_done
    );

    modport slave (
        input  o_alu_start, o_s1, o_s2, o_op,
        output i_res, i_res_sign, i_res_err, i_alu_done
    );
endinterface

// File: rtl/calc_sequencer.sv
// Operand/result sequencer: captures operands on enter edges, runs the ALU start/done handshake, latches the result.
// Define CALC_CHAIN_EN to chain a new operand onto the previous result (RESULT -> CONT -> CALC).
module calc_sequencer #(
    parameter int DIGITS      = 10,
    parameter int ALU_TIMEOUT = 15
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enter,
    input  logic                i_clear,
    input  logic                i_enable,
    input  logic [4*DIGITS-1:0] i_val,
    input  logic [1:0]          i_op,
    calc_sequencer_if.master    alu,
    output logic [4*DIGITS-1:0] o_res,
    output logic                o_sign,
    output logic [1:0]          o_disp_sel,
    output logic [3:0]          o_led,
    output logic                o_err
);
    localparam int W = 4*DIGITS;

    typedef enum logic [2:0] {
        ST_IN1, ST_IN2, ST_CALC, ST_RESULT, ST_CONT, ST_ERR
    } state_t;

    state_t       state_q;
    logic         enter_q;
    logic         alu_start_q;
    logic [W-1:0] s1_q, s2_q, res_q;
    logic [1:0]   op_q;
    logic         sign_q;
    logic [1:0]   disp_q;
    logic [3:0]   led_q;
    logic         err_q;
    logic [7:0]   tmo_cnt_q;
    logic         enter_evt;

    // enter_q tracks the button in every state so re-enabling never produces a stale edge
    assign enter_evt = i_enter & ~enter_q & i_enable;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IN1;
            enter_q     <= 1'b0;
            alu_start_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            res_q       <= '0;
            op_q        <= 2'b00;
            sign_q      <= 1'b0;
            disp_q      <= 2'b00;
            led_q       <= 4'b0000;
            err_q       <= 1'b0;
            tmo_cnt_q   <= 8'd0;
        end else begin
            enter_q     <= i_enter;
            alu_start_q <= 1'b0;
            if (i_clear) begin
                state_q   <= ST_IN1;
                s1_q      <= '0;
                s2_q      <= '0;
                res_q     <= '0;
                op_q      <= 2'b00;
                sign_q    <= 1'b0;
                disp_q    <= 2'b00;
                led_q     <= 4'b0000;
                err_q     <= 1'b0;
                tmo_cnt_q <= 8'd0;
            end else begin
                case (state_q)
                    ST_IN1: if (enter_evt) begin
                        s1_q    <= i_val;
                        state_q <= ST_IN2;
                        disp_q  <= 2'b01;
                        led_q   <= 4'b0001;
                    end
                    ST_IN2: if (enter_evt) begin
                        s2_q        <= i_val;
                        op_q        <= i_op;
                        alu_start_q <= 1'b1;
                        tmo_cnt_q   <= 8'd0;
                        state_q     <= ST_CALC;
                        led_q       <= 4'b0010;
                    end
                    ST_CALC: begin
                        // a done on the timeout edge still delivers its result
                        if (alu.i_alu_done && !alu.i_res_err) begin
                            res_q   <= alu.i_res;
                            sign_q  <= alu.i_res_sign;
                            state_q <= ST_RESULT;
                            disp_q  <= 2'b11;
                        end else if (alu.i_alu_done || tmo_cnt_q == 8'(ALU_TIMEOUT)) begin
                            state_q <= ST_ERR;
                            disp_q  <= 2'b10;
                            led_q   <= 4'b1111;
                            err_q   <= 1'b1;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 8'd1;
                        end
                    end
`ifdef CALC_CHAIN_EN
                    ST_RESULT: if (enter_evt) begin
                        state_q <= ST_CONT;
                        disp_q  <= 2'b01;
                        led_q   <= 4'b0100;
                    end
                    ST_CONT: if (enter_evt) begin
                        s1_q        <= res_q;
                        s2_q        <= i_val;
                        op_q        <= i_op;
                        alu_start_q <= 1'b1;
                        tmo_cnt_q   <= 8'd0;
                        state_q     <= ST_CALC;
                        led_q       <= 4'b1000;
                    end
`else
                    ST_RESULT: if (enter_evt) begin
                        s1_q    <= '0;
                        s2_q    <= '0;
                        state_q <= ST_IN1;
                        disp_q  <= 2'b00;
                        led_q   <= 4'b0000;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign alu.o_alu_start = alu_start_q;
    assign alu.o_s1        = s1_q;
    assign alu.o_s2        = s2_q;
    assign alu.o_op        = op_q;
    assign o_res           = res_q;
    assign o_sign          = sign_q;
    assign o_disp_sel      = disp_q;
    assign o_led           = led_q;
    assign o_err           = err_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed test-plan steps followed by random stimulus against a cycle model.
module tb_calc_sequencer;
    localparam int DIGITS = 10;
    localparam int W      = 4*DIGITS;
    localparam int TMO    = 15;
`ifdef CALC_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    typedef enum {M_FIRST, M_SECOND, M_BUSY, M_SHOW, M_CHAIN, M_FAULT} mode_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enter, clear, enable;
    logic [W-1:0] val;
    logic [1:0]   op;
    logic [W-1:0] res_o;
    logic         sign_o;
    logic [1:0]   disp;
    logic [3:0]   led;
    logic         err;

    calc_sequencer_if #(.W(W)) alu ();

    calc_sequencer #(.DIGITS(DIGITS), .ALU_TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enter(enter), .i_clear(clear),
        .i_enable(enable), .i_val(val), .i_op(op), .alu(alu),
        .o_res(res_o), .o_sign(sign_o), .o_disp_sel(disp), .o_led(led), .o_err(err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    mode_t        m_mode;
    logic [W-1:0] m_s1, m_s2, m_res;
    logic [1:0]   m_op, m_disp;
    logic [3:0]   m_led;
    logic         m_sign, m_err, m_start, m_prev;
    int           m_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("s1",    64'(alu.o_s1),        64'(m_s1));
        chk("s2",    64'(alu.o_s2),        64'(m_s2));
        chk("op",    64'(alu.o_op),        64'(m_op));
        chk("start", 64'(alu.o_alu_start), 64'(m_start));
        chk("res",   64'(res_o),           64'(m_res));
        chk("sign",  64'(sign_o),          64'(m_sign));
        chk("disp",  64'(disp),            64'(m_disp));
        chk("led",   64'(led),             64'(m_led));
        chk("err",   64'(err),             64'(m_err));
    endtask

    task automatic m_reset();
        m_mode = M_FIRST; m_s1 = '0; m_s2 = '0; m_res = '0; m_op = 2'b00; m_disp = 2'b00;
        m_led = 4'b0000; m_sign = 1'b0; m_err = 1'b0; m_start = 1'b0; m_prev = 1'b0; m_busy = 0;
    endtask

    // Predicts the post-edge outputs from the pre-edge inputs, clocks once, then compares.
    task automatic tick();
        mode_t        n_mode  = m_mode;
        logic [W-1:0] n_s1    = m_s1, n_s2 = m_s2, n_res = m_res;
        logic [1:0]   n_op    = m_op, n_disp = m_disp;
        logic [3:0]   n_led   = m_led;
        logic         n_sign  = m_sign, n_err = m_err;
        logic         n_start = 1'b0;
        int           n_busy  = m_busy;
        bit           ev      = enter && !m_prev && enable;
        bit           n_prev  = enter;
        if (clear) begin
            n_mode = M_FIRST; n_s1 = '0; n_s2 = '0; n_res = '0; n_op = 2'b00;
            n_sign = 1'b0; n_disp = 2'b00; n_led = 4'b0000; n_err = 1'b0; n_busy = 0;
        end else begin
            case (m_mode)
                M_FIRST: if (ev) begin
                    n_s1 = val; n_mode = M_SECOND; n_disp = 2'b01; n_led = 4'b0001;
                end
                M_SECOND: if (ev) begin
                    n_s2 = val; n_op = op; n_start = 1'b1; n_mode = M_BUSY; n_led = 4'b0010; n_busy = 0;
                end
                M_BUSY: begin
                    n_busy = m_busy + 1;
                    if (alu.i_alu_done && !alu.i_res_err) begin
                        n_res = alu.i_res; n_sign = alu.i_res_sign; n_mode = M_SHOW; n_disp = 2'b11;
                    end else if (alu.i_alu_done || n_busy > TMO) begin
                        n_mode = M_FAULT; n_disp = 2'b10; n_led = 4'b1111; n_err = 1'b1;
                    end
                end
                M_SHOW: if (ev) begin
                    if (CHAIN) begin
                        n_mode = M_CHAIN; n_disp = 2'b01; n_led = 4'b0100;
                    end else begin
                        n_mode = M_FIRST; n_s1 = '0; n_s2 = '0; n_disp = 2'b00; n_led = 4'b0000;
                    end
                end
                M_CHAIN: if (ev) begin
                    n_s1 = m_res; n_s2 = val; n_op = op; n_start = 1'b1;
                    n_mode = M_BUSY; n_led = 4'b1000; n_busy = 0;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        m_mode = n_mode; m_s1 = n_s1; m_s2 = n_s2; m_res = n_res; m_op = n_op; m_disp = n_disp;
        m_led = n_led; m_sign = n_sign; m_err = n_err; m_start = n_start; m_prev = n_prev; m_busy = n_busy;
        #1;
        check_all();
    endtask

    task automatic press(input logic [W-1:0] v, input logic [1:0] o);
        val = v; op = o; enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enter = 1'b0; clear = 1'b0; enable = 1'b1; val = '0; op = 2'b00;
        alu.i_res = '0; alu.i_res_sign = 1'b0; alu.i_res_err = 1'b0; alu.i_alu_done = 1'b0;
        m_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // two operands, start pulse on the second press
        press(40'h12, 2'b00);
        chk("dir_s1", 64'(alu.o_s1), 64'h12);
        chk("dir_led_in2", 64'(led), 64'h1);
        val = 40'h34; op = 2'b01; enter = 1'b1;
        tick();
        enter = 1'b0;
        chk("dir_start_hi", 64'(alu.o_alu_start), 64'h1);
        chk("dir_s2", 64'(alu.o_s2), 64'h34);
        chk("dir_op", 64'(alu.o_op), 64'h1);
        chk("dir_led_calc", 64'(led), 64'h2);
        tick();
        chk("dir_start_lo", 64'(alu.o_alu_start), 64'h0);
        tick();
        alu.i_alu_done = 1'b1; alu.i_res = 40'h46; alu.i_res_sign = 1'b0;
        tick();
        alu.i_alu_done = 1'b0;
        chk("dir_res", 64'(res_o), 64'h46);
        chk("dir_disp_res", 64'(disp), 64'h3);

        // enter held: exactly one transition out of RESULT
        enter = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        enter = 1'b0;
        tick();
        chk("dir_held_disp", 64'(disp), CHAIN ? 64'h1 : 64'h0);
`ifdef CALC_CHAIN_EN
        press(40'h05, 2'b10);
        chk("dir_chain_s1", 64'(alu.o_s1), 64'h46);
        chk("dir_chain_s2", 64'(alu.o_s2), 64'h05);
        chk("dir_chain_led", 64'(led), 64'h8);
`else
        chk("dir_ret_s1", 64'(alu.o_s1), 64'h0);
        chk("dir_ret_res", 64'(res_o), 64'h46);
`endif
        do_clear();

        // timeout: still waiting after TMO edges, error on the next
        press(40'h7, 2'b00);
        press(40'h8, 2'b11);
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("tmo_not_yet", 64'(err), 64'h0);
        tick();
        chk("tmo_err", 64'(err), 64'h1);
        chk("tmo_led", 64'(led), 64'hF);
        press(40'h9, 2'b01);
        chk("err_sticky", 64'(disp), 64'h2);
        do_clear();
        tick();
        chk("clr_s1", 64'(alu.o_s1), 64'h0);
        chk("clr_led", 64'(led), 64'h0);

        // ALU error flag with done
        press(40'h1, 2'b00);
        press(40'h2, 2'b00);
        alu.i_alu_done = 1'b1; alu.i_res_err = 1'b1;
        tick();
        alu.i_alu_done = 1'b0; alu.i_res_err = 1'b0;
        chk("alu_err", 64'(err), 64'h1);
        do_clear();

        // disabled press, then re-enable with enter still held
        enable = 1'b0; enter = 1'b1; val = 40'h55;
        tick();
        enable = 1'b1;
        tick();
        tick();
        chk("en_held_disp", 64'(disp), 64'h0);
        enter = 1'b0;
        tick();
        press(40'h66, 2'b00);
        chk("en_press_s1", 64'(alu.o_s1), 64'h66);

        // async reset right after the start edge; late done ignored
        val = 40'h3; op = 2'b10; enter = 1'b1;
        tick();
        enter = 1'b0;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        #2;
        rst_n = 1'b1;
        alu.i_alu_done = 1'b1; alu.i_res = 40'hAB;
        tick();
        alu.i_alu_done = 1'b0;
        tick();
        chk("rst_done_ign", 64'(res_o), 64'h0);

        // random stimulus
        for (int n = 0; n < 1500; n++) begin
            enter          = 1'($urandom_range(0, 1));
            clear          = ($urandom_range(0, 39) == 0);
            enable         = ($urandom_range(0, 7) != 0);
            val            = {8'($urandom), $urandom};
            op             = 2'($urandom);
            alu.i_alu_done = ($urandom_range(0, 5) == 0);
            alu.i_res_err  = ($urandom_range(0, 4) == 0);
            alu.i_res      = {8'($urandom), $urandom};
            alu.i_res_sign = 1'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
